// File: rtl/shift_reg_param_piso_serializer.sv
// PISO shift register with a valid/ready word load and per-bit valid/last
// flags; a load on the last bit of a word streams the next word gap-free.
module shift_reg_param_piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             C,
  input  logic             R,
  input  logic             CE,
  input  logic             LOAD_VALID,
  output logic             LOAD_READY,
  input  logic [WIDTH-1:0] D,
  input  logic             SI,
  output logic             SO,
  output logic             SO_VALID,
  output logic             SO_LAST,
  output logic             BUSY
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] shifted;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             accept;

  assign last = (cnt == '0);

  assign LOAD_READY = (state == IDLE)
                    | ((state == SHIFT) & CE & last);
  assign accept = LOAD_VALID & LOAD_READY;

  // SI enters at the end opposite to SO
  assign shifted = MSB_FIRST ? {sreg[WIDTH-2:0], SI}
                             : {SI, sreg[WIDTH-1:1]};

  assign SO       = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
  assign BUSY     = (state == SHIFT);
  assign SO_VALID = BUSY;
  assign SO_LAST  = BUSY & last;

  always_ff @(posedge C) begin
    if (R) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else if (accept) begin
      state <= SHIFT;
      sreg  <= D;
      cnt   <= CW'(WIDTH - 1);
    end else if ((state == SHIFT) && CE) begin
      sreg <= shifted;
      if (last) begin
        state <= IDLE;
      end else begin
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_shift_reg_param_piso_serializer.sv
// Scoreboard bench for shift_reg_param_piso_serializer: one MSB-first and
// one LSB-first instance share random stimulus; queues hold expected bits.
module tb_shift_reg_param_piso_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         R   = 1'b1;
  logic         CE  = 1'b0;
  logic         LV  = 1'b0;
  logic         SI  = 1'b0;
  logic [W-1:0] D   = '0;

  int tests = 0;
  int fails = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int ln,
                     input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s lane%0d t=%0t: got %b want %b",
               nm, ln, $time, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam bit MF = (g == 0);

    logic       ready;
    logic       so;
    logic       sov;
    logic       sol;
    logic       busy;
    logic [1:0] q[$];
    logic       fill[$];

    shift_reg_param_piso_serializer #(
      .WIDTH(W),
      .MSB_FIRST(MF)
    ) dut (
      .C(clk),
      .R(R),
      .CE(CE),
      .LOAD_VALID(LV),
      .LOAD_READY(ready),
      .D(D),
      .SI(SI),
      .SO(so),
      .SO_VALID(sov),
      .SO_LAST(sol),
      .BUSY(busy)
    );

    // monitor: head of q is the bit that must be on SO now
    always @(negedge clk) begin
      logic [1:0] hd;
      logic       fb;
      if (started) begin
        if (q.size() != 0) begin
          hd = q[0];
          chk("so_valid", g, sov, 1'b1);
          chk("busy", g, busy, 1'b1);
          chk("so", g, so, hd[0]);
          chk("so_last", g, sol, hd[1]);
          if (CE) begin
            hd = q.pop_front();
            fill.push_back(SI);
            if (fill.size() > W) fb = fill.pop_front();
          end
        end else begin
          chk("idle_valid", g, sov, 1'b0);
          chk("idle_busy", g, busy, 1'b0);
          chk("idle_last", g, sol, 1'b0);
          if (fill.size() == W) chk("idle_so", g, so, fill[0]);
        end
      end
    end

    // model: a word is accepted only once the previous one is drained
    always @(negedge clk) begin
      bit rexp;
      if (started) begin
        #1;
        rexp = (q.size() == 0);
        chk("load_ready", g, ready, rexp);
        if (R) begin
          q.delete();
          fill.delete();
          for (int i = 0; i < W; i++) fill.push_back(1'b0);
        end else if (LV && rexp) begin
          for (int i = 0; i < W; i++) begin
            int idx;
            idx = MF ? (W - 1 - i) : i;
            q.push_back({(i == W - 1), D[idx]});
          end
        end
      end
    end
  end

  task automatic step(input logic ce, input logic lv, input logic si,
                      input logic r, input logic [W-1:0] d,
                      output bit acc);
    CE = ce;
    LV = lv;
    SI = si;
    R  = r;
    D  = d;
    #2;
    acc = lv && !r && lane[0].ready;
    @(posedge clk);
    #1;
  endtask

  function automatic logic pick_ce(input int pct);
    return ($urandom_range(99) < pct);
  endfunction

  function automatic logic pick_si(input int mode);
    return (mode == 2) ? logic'($urandom_range(1)) : logic'(mode);
  endfunction

  // si_mode: 0/1 fixed SI value, 2 random
  task automatic send(input logic [W-1:0] d, input int pct,
                      input int si_mode);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < 64 && !acc; i++)
      step(pick_ce(pct), 1'b1, pick_si(si_mode), 1'b0, d, acc);
    tests++;
    if (!acc) begin
      fails++;
      $display("FAIL accept_timeout: got no accept want accept");
    end
  endtask

  task automatic idle(input int n, input int pct, input int si_mode);
    bit acc;
    for (int i = 0; i < n; i++)
      step(pick_ce(pct), 1'b0, pick_si(si_mode), 1'b0,
           W'($urandom), acc);
  endtask

  initial begin
    bit acc;
    @(posedge clk);
    #1;
    started = 1'b1;
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, acc);
    idle(2, 100, 0);

    send(8'hA5, 100, 0);
    idle(10, 100, 0);

    send(8'h01, 100, 0);
    idle(10, 100, 0);

    send(8'hFF, 100, 2);
    send(8'h00, 100, 2);
    idle(10, 100, 2);

    send(8'hC3, 100, 2);
    for (int i = 0; i < 16; i++)
      step(logic'(i % 2 == 1), 1'b0, 1'b0, 1'b0, 8'h00, acc);
    idle(4, 100, 0);

    send(8'h5A, 100, 2);
    idle(2, 100, 2);
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, acc);
    idle(2, 100, 0);
    send(8'h96, 100, 2);
    idle(10, 100, 2);

    send(8'h00, 100, 1);
    idle(12, 100, 1);

    for (int n = 0; n < 200; n++) begin
      int pct;
      case ($urandom_range(2))
        0:       pct = 100;
        1:       pct = 70;
        default: pct = 40;
      endcase
      send(W'($urandom), pct, 2);
      if ($urandom_range(19) == 0) begin
        idle($urandom_range(6), pct, 2);
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, acc);
      end
      idle($urandom_range(3), pct, 2);
    end
    idle(40, 100, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
